// File: rtl/axi_pattern_if.sv
// AXI4 bus bundle between a master and the pattern slave.
// The slave modport is the DUT view; the master modport is the driver view.
interface axi_pattern_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_pattern_slave.sv
// AXI4 slave that returns an address-derived pattern on reads and checks it on writes.
// Read and write channels run independent FSMs; write errors accumulate in err_count.
module axi_pattern_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    axi_pattern_if.slave s_axi,
    output logic [31:0] err_count,
    output logic [15:0] wr_bursts,
    output logic [15:0] rd_bursts
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LANES = DATA_WIDTH / 32;
    localparam int LSB   = $clog2(BYTES);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] base;
        logic [31:0]           base32;
        pattern = '0;
        base = addr;
        base[LSB-1:0] = '0;
        base32 = 32'(base);
        for (int i = 0; i < LANES; i++) begin
            pattern[32*i +: 32] = base32 + 32'(4 * i);
        end
    endfunction

    function automatic logic beat_mismatch(input logic [DATA_WIDTH-1:0] data,
                                           input logic [BYTES-1:0]      strb,
                                           input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] expv;
        expv = pattern(addr);
        beat_mismatch = 1'b0;
        for (int b = 0; b < BYTES; b++) begin
            if (strb[b] && (data[8*b +: 8] != expv[8*b +: 8])) beat_mismatch = 1'b1;
        end
    endfunction

    function automatic logic unsupported(input logic [1:0] burst, input logic [2:0] size);
        unsupported = burst[1] || (size != 3'(LSB));
    endfunction

    // FIXED holds the address; every other burst type advances one bus width per beat
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [1:0] burst);
        next_addr = (burst == 2'b00) ? addr : addr + ADDR_WIDTH'(BYTES);
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, a} + {31'd0, inc};
        sat_add = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    w_state_t              w_state_r, w_state_s;
    r_state_t              r_state_r, r_state_s;
    logic [ADDR_WIDTH-1:0] w_addr_r, r_addr_r, r_next_addr_s;
    logic [7:0]            w_len_r, w_cnt_r, r_len_r, r_cnt_r;
    logic [1:0]            w_burst_r, r_burst_r;
    logic                  w_bad_r;
    logic                  aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
    logic                  w_last_beat_s, w_mismatch_s, w_lasterr_s;
    logic                  unused_ctrl_s;

    assign aw_hs_s       = (w_state_r == W_IDLE) && s_axi.awvalid;
    assign w_hs_s        = (w_state_r == W_DATA) && s_axi.wvalid;
    assign b_hs_s        = (w_state_r == W_RESP) && s_axi.bready;
    assign ar_hs_s       = (r_state_r == R_IDLE) && s_axi.arvalid;
    assign r_hs_s        = (r_state_r == R_DATA) && s_axi.rready;
    assign w_last_beat_s = (w_cnt_r == w_len_r);
    assign w_mismatch_s  = beat_mismatch(s_axi.wdata, s_axi.wstrb, w_addr_r);
    assign w_lasterr_s   = (s_axi.wlast != w_last_beat_s);
    assign r_next_addr_s = next_addr(r_addr_r, r_burst_r);
    assign unused_ctrl_s = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot,
                             s_axi.arlock, s_axi.arcache, s_axi.arprot};

    // State registers for both channel FSMs
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_r <= W_IDLE;
            r_state_r <= R_IDLE;
        end else begin
            w_state_r <= w_state_s;
            r_state_r <= r_state_s;
        end
    end

    // Write FSM next state and handshake outputs; ready/valid are forced low during reset
    always_comb begin
        w_state_s     = w_state_r;
        s_axi.awready = 1'b0;
        s_axi.wready  = 1'b0;
        s_axi.bvalid  = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                s_axi.awready = !rst;
                if (aw_hs_s) w_state_s = W_DATA;
                else         w_state_s = W_IDLE;
            end
            W_DATA: begin
                s_axi.wready = !rst;
                if (w_hs_s && w_last_beat_s) w_state_s = W_RESP;
                else                         w_state_s = W_DATA;
            end
            W_RESP: begin
                s_axi.bvalid = !rst;
                if (b_hs_s) w_state_s = W_IDLE;
                else        w_state_s = W_RESP;
            end
            default: w_state_s = W_IDLE;
        endcase
    end

    // Read FSM next state and handshake outputs
    always_comb begin
        r_state_s     = r_state_r;
        s_axi.arready = 1'b0;
        s_axi.rvalid  = 1'b0;
        case (r_state_r)
            R_IDLE: begin
                s_axi.arready = !rst;
                if (ar_hs_s) r_state_s = R_DATA;
                else         r_state_s = R_IDLE;
            end
            R_DATA: begin
                s_axi.rvalid = !rst;
                if (r_hs_s && s_axi.rlast) r_state_s = R_IDLE;
                else                       r_state_s = R_DATA;
            end
            default: r_state_s = R_IDLE;
        endcase
    end

    // Write datapath: burst capture, per-beat checking, response and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            w_addr_r    <= '0;
            w_len_r     <= 8'd0;
            w_cnt_r     <= 8'd0;
            w_burst_r   <= 2'b00;
            w_bad_r     <= 1'b0;
            s_axi.bid   <= '0;
            s_axi.bresp <= 2'b00;
            err_count   <= 32'd0;
            wr_bursts   <= 16'd0;
        end else begin
            if (aw_hs_s) begin
                w_addr_r  <= s_axi.awaddr;
                w_len_r   <= s_axi.awlen;
                w_cnt_r   <= 8'd0;
                w_burst_r <= s_axi.awburst;
                w_bad_r   <= unsupported(s_axi.awburst, s_axi.awsize);
                s_axi.bid <= s_axi.awid;
            end
            if (w_hs_s) begin
                err_count <= sat_add(err_count, {1'b0, w_mismatch_s} + {1'b0, w_lasterr_s});
                w_bad_r   <= w_bad_r | w_mismatch_s | w_lasterr_s;
                w_addr_r  <= next_addr(w_addr_r, w_burst_r);
                w_cnt_r   <= w_cnt_r + 8'd1;
                if (w_last_beat_s) begin
                    s_axi.bresp <= (w_bad_r | w_mismatch_s | w_lasterr_s) ? 2'b10 : 2'b00;
                end
            end
            if (b_hs_s) wr_bursts <= wr_bursts + 16'd1;
        end
    end

    // Read datapath: the next beat is prepared on each handshake so there are no bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_r    <= '0;
            r_len_r     <= 8'd0;
            r_cnt_r     <= 8'd0;
            r_burst_r   <= 2'b00;
            s_axi.rid   <= '0;
            s_axi.rdata <= '0;
            s_axi.rresp <= 2'b00;
            s_axi.rlast <= 1'b0;
            rd_bursts   <= 16'd0;
        end else if (ar_hs_s) begin
            r_addr_r    <= s_axi.araddr;
            r_len_r     <= s_axi.arlen;
            r_cnt_r     <= 8'd0;
            r_burst_r   <= s_axi.arburst;
            s_axi.rid   <= s_axi.arid;
            s_axi.rdata <= pattern(s_axi.araddr);
            s_axi.rresp <= unsupported(s_axi.arburst, s_axi.arsize) ? 2'b10 : 2'b00;
            s_axi.rlast <= (s_axi.arlen == 8'd0);
        end else if (r_hs_s) begin
            if (s_axi.rlast) begin
                rd_bursts   <= rd_bursts + 16'd1;
                s_axi.rlast <= 1'b0;
            end else begin
                r_addr_r    <= r_next_addr_s;
                r_cnt_r     <= r_cnt_r + 8'd1;
                s_axi.rdata <= pattern(r_next_addr_s);
                s_axi.rlast <= ((r_cnt_r + 8'd1) == r_len_r);
            end
        end
    end
endmodule

// File: tb/tb_axi_pattern_slave.sv
// Self-checking bench for axi_pattern_slave: directed scenarios plus randomized bursts
// checked against a behavioural pattern/error model.
module tb_axi_pattern_slave;
    localparam int AW = 32;
    localparam int DW = 256;
    localparam int IW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] err_count;
    logic [15:0] wr_bursts;
    logic [15:0] rd_bursts;

    int total = 0;
    int bad   = 0;
    int exp_err = 0;
    int exp_wr  = 0;
    int exp_rd  = 0;

    logic [255:0] wd [16];
    logic [31:0]  ws [16];
    logic         wl [16];

    always #5 clk = ~clk;

    axi_pattern_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    axi_pattern_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_axi     (bus.slave),
        .err_count (err_count),
        .wr_bursts (wr_bursts),
        .rd_bursts (rd_bursts)
    );

    // Beat k of a burst starting at 'start': 8 lanes counting up by 4 from the 32-byte aligned address
    function automatic logic [255:0] model_beat(input logic [31:0] start, input int k, input logic [1:0] burst);
        logic [31:0]  a;
        logic [31:0]  base;
        logic [255:0] r;
        a = (burst == 2'b00) ? start : start + 32'(32 * k);
        base = a & 32'hFFFF_FFE0;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = base + 32'(4 * i);
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic fill_good(input logic [31:0] addr, input int len, input logic [1:0] burst);
        for (int k = 0; k <= len; k++) begin
            wd[k] = model_beat(addr, k, burst);
            ws[k] = 32'hFFFF_FFFF;
            wl[k] = (k == len);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_awready", bus.awready, 1'b0);
        check("rst_arready", bus.arready, 1'b0);
        check("rst_wready", bus.wready, 1'b0);
        check("rst_bvalid", bus.bvalid, 1'b0);
        check("rst_rvalid", bus.rvalid, 1'b0);
        check("rst_rlast", bus.rlast, 1'b0);
        check("rst_bresp", bus.bresp, 2'b00);
        check("rst_rresp", bus.rresp, 2'b00);
        check("rst_bid", bus.bid, 8'h00);
        check("rst_rid", bus.rid, 8'h00);
        check("rst_rdata", bus.rdata, 256'd0);
        check("rst_err_count", err_count, 32'd0);
        check("rst_wr_bursts", wr_bursts, 16'd0);
        check("rst_rd_bursts", rd_bursts, 16'd0);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        exp_err = 0;
        exp_wr  = 0;
        exp_rd  = 0;
        #1;
        check("post_rst_awready", bus.awready, 1'b1);
        check("post_rst_arready", bus.arready, 1'b1);
    endtask

    // stall_mode: 0 = rready always 1, 1 = rready 1,0,0,1,1..., 2 = random rready
    task automatic read_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [2:0] size, input int stall_mode);
        int  k;
        int  cyc;
        bit  rr;
        logic [1:0] eresp;
        eresp = (burst[1] || size != 3'd5) ? 2'b10 : 2'b00;
        @(negedge clk);
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arburst = burst; bus.arsize = size;
        bus.arlock = 1'($urandom); bus.arcache = 4'($urandom); bus.arprot = 3'($urandom);
        bus.arvalid = 1'b1;
        check("arready_idle", bus.arready, 1'b1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        check("rvalid_first", bus.rvalid, 1'b1);
        check("arready_busy", bus.arready, 1'b0);
        k = 0;
        cyc = 0;
        while (k <= int'(len) && cyc < 400) begin
            case (stall_mode)
                0:       rr = 1'b1;
                1:       rr = !(cyc == 1 || cyc == 2);
                default: rr = 1'($urandom_range(0, 1));
            endcase
            bus.rready = rr;
            check("rvalid", bus.rvalid, 1'b1);
            check("rdata", bus.rdata, model_beat(addr, k, burst));
            check("rid", bus.rid, id);
            check("rresp", bus.rresp, eresp);
            check("rlast", bus.rlast, (k == int'(len)));
            @(negedge clk);
            if (rr) k++;
            cyc++;
        end
        bus.rready = 1'b0;
        exp_rd++;
        check("rvalid_done", bus.rvalid, 1'b0);
        check("arready_done", bus.arready, 1'b1);
        check("rd_bursts", rd_bursts, 16'(exp_rd));
    endtask

    task automatic write_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic [2:0] size, input bit gaps, input int bdelay);
        int  k;
        int  guard;
        bit  any_err;
        bit  mm;
        bit  le;
        logic [255:0] ev;
        any_err = (burst[1] || size != 3'd5);
        for (int j = 0; j <= int'(len); j++) begin
            ev = model_beat(addr, j, burst);
            mm = 1'b0;
            for (int b = 0; b < 32; b++) begin
                if (ws[j][b] && wd[j][8*b +: 8] != ev[8*b +: 8]) mm = 1'b1;
            end
            le = (wl[j] != (j == int'(len)));
            exp_err = exp_err + int'(mm) + int'(le);
            any_err = any_err | mm | le;
        end
        @(negedge clk);
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awburst = burst; bus.awsize = size;
        bus.awlock = 1'($urandom); bus.awcache = 4'($urandom); bus.awprot = 3'($urandom);
        bus.awvalid = 1'b1;
        check("awready_idle", bus.awready, 1'b1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        check("awready_busy", bus.awready, 1'b0);
        k = 0;
        guard = 0;
        while (k <= int'(len) && guard < 400) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.wvalid = 1'b0;
            end else begin
                bus.wdata = wd[k]; bus.wstrb = ws[k]; bus.wlast = wl[k]; bus.wvalid = 1'b1;
            end
            check("wready", bus.wready, 1'b1);
            check("bvalid_early", bus.bvalid, 1'b0);
            @(negedge clk);
            if (bus.wvalid) k++;
            guard++;
        end
        bus.wvalid = 1'b0;
        bus.wlast = 1'b0;
        check("bvalid", bus.bvalid, 1'b1);
        check("wready_resp", bus.wready, 1'b0);
        check("bid", bus.bid, id);
        check("bresp", bus.bresp, any_err ? 2'b10 : 2'b00);
        repeat (bdelay) begin
            @(negedge clk);
            check("bvalid_hold", bus.bvalid, 1'b1);
        end
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        exp_wr++;
        check("bvalid_done", bus.bvalid, 1'b0);
        check("awready_done", bus.awready, 1'b1);
        check("wr_bursts", wr_bursts, 16'(exp_wr));
        check("err_count", err_count, 32'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.awid = '0; bus.awaddr = '0; bus.awlen = 8'd0; bus.awsize = 3'd0; bus.awburst = 2'b00;
        bus.awlock = 1'b0; bus.awcache = 4'd0; bus.awprot = 3'd0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = 8'd0; bus.arsize = 3'd0; bus.arburst = 2'b00;
        bus.arlock = 1'b0; bus.arcache = 4'd0; bus.arprot = 3'd0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        do_reset(3);

        // Basic INCR read, including explicit lane values
        read_burst(8'h11, 32'h40, 8'd3, 2'b01, 3'd5, 0);
        check("model_b0_l0", model_beat(32'h40, 0, 2'b01) & 256'hFFFF_FFFF, 256'h40);

        // Clean two-beat write, then corruption masked / unmasked by strobes
        fill_good(32'h100, 1, 2'b01);
        write_burst(8'h22, 32'h100, 8'd1, 2'b01, 3'd5, 1'b0, 0);
        fill_good(32'h100, 1, 2'b01);
        wd[1][31:0] = 32'hDEAD;
        ws[1][3:0] = 4'h0;
        write_burst(8'h23, 32'h100, 8'd1, 2'b01, 3'd5, 1'b0, 0);
        ws[1] = 32'hFFFF_FFFF;
        write_burst(8'h24, 32'h100, 8'd1, 2'b01, 3'd5, 1'b0, 2);
        check("err_after_corrupt", err_count, 32'd1);

        // Backpressure on a three-beat read
        read_burst(8'h33, 32'h1000, 8'd2, 2'b01, 3'd5, 1);

        // Early wlast on beat 1, missing wlast on beat 3
        fill_good(32'h200, 3, 2'b01);
        wl[1] = 1'b1;
        wl[3] = 1'b0;
        write_burst(8'h44, 32'h200, 8'd3, 2'b01, 3'd5, 1'b0, 0);
        check("err_after_wlast", err_count, 32'd3);

        // Single beat carrying both a data mismatch and a wlast error
        fill_good(32'h300, 0, 2'b01);
        wd[0][39:32] = ~wd[0][39:32];
        wl[0] = 1'b0;
        write_burst(8'h55, 32'h300, 8'd0, 2'b01, 3'd5, 1'b0, 0);
        check("err_after_double", err_count, 32'd5);

        // FIXED bursts, unsupported size write, address wraparound, single-beat read
        fill_good(32'h520, 2, 2'b00);
        write_burst(8'h66, 32'h524, 8'd2, 2'b00, 3'd5, 1'b1, 1);
        read_burst(8'h67, 32'h52C, 8'd2, 2'b00, 3'd5, 2);
        fill_good(32'h600, 1, 2'b01);
        write_burst(8'h68, 32'h600, 8'd1, 2'b01, 3'd4, 1'b0, 0);
        read_burst(8'h69, 32'hFFFF_FFE0, 8'd1, 2'b01, 3'd5, 0);
        read_burst(8'h6A, 32'h7F0, 8'd0, 2'b01, 3'd5, 0);

        // Randomized traffic
        for (int it = 0; it < 16; it++) begin
            logic [31:0] a;
            logic [7:0]  l;
            logic [1:0]  bt;
            a  = $urandom;
            l  = 8'($urandom_range(0, 7));
            bt = 2'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) begin
                read_burst(8'($urandom), a, l, bt, 3'd5, 2);
            end else begin
                fill_good(a, int'(l), bt);
                for (int k = 0; k <= int'(l); k++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        int bi;
                        bi = $urandom_range(0, 31);
                        wd[k][8*bi +: 8] = ~wd[k][8*bi +: 8];
                        ws[k] = $urandom;
                    end
                    if ($urandom_range(0, 7) == 0) wl[k] = ~wl[k];
                end
                write_burst(8'($urandom), a, l, bt, 3'd5, 1'b1, $urandom_range(0, 2));
            end
        end

        // Concurrent erroneous write and read must not interact
        fill_good(32'h900, 3, 2'b01);
        wd[2][7:0] = ~wd[2][7:0];
        fork
            write_burst(8'h77, 32'h900, 8'd3, 2'b01, 3'd5, 1'b0, 1);
            read_burst(8'h78, 32'hA00, 8'd3, 2'b01, 3'd5, 0);
        join

        // WRAP read answered with SLVERR on every beat
        read_burst(8'h88, 32'h800, 8'd1, 2'b10, 3'd5, 0);

        // Reset in the middle of a WRAP read and of a write
        @(negedge clk);
        bus.arid = 8'h99; bus.araddr = 32'hC00; bus.arlen = 8'd3; bus.arburst = 2'b10; bus.arsize = 3'd5;
        bus.arvalid = 1'b1;
        fill_good(32'hD00, 3, 2'b01);
        bus.awid = 8'h9A; bus.awaddr = 32'hD00; bus.awlen = 8'd3; bus.awburst = 2'b01; bus.awsize = 3'd5;
        bus.awvalid = 1'b1;
        @(negedge clk);
        bus.arvalid = 1'b0;
        bus.awvalid = 1'b0;
        check("mid_rresp", bus.rresp, 2'b10);
        bus.rready = 1'b1;
        bus.wdata = wd[0]; bus.wstrb = ws[0]; bus.wlast = 1'b0; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        bus.wvalid = 1'b0;
        check("mid_rvalid", bus.rvalid, 1'b1);
        do_reset(2);
        repeat (3) @(negedge clk);
        check("post_mid_rvalid", bus.rvalid, 1'b0);
        check("post_mid_bvalid", bus.bvalid, 1'b0);
        check("post_mid_wready", bus.wready, 1'b0);
        check("post_mid_rd_bursts", rd_bursts, 16'd0);
        check("post_mid_wr_bursts", wr_bursts, 16'd0);

        // Normal operation resumes after the abandoned bursts
        read_burst(8'hA1, 32'h40, 8'd3, 2'b01, 3'd5, 0);
        fill_good(32'h100, 1, 2'b01);
        write_burst(8'hA2, 32'h100, 8'd1, 2'b01, 3'd5, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
